serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial LSB-first unsigned subtractor (a - b) with borrow out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bor;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             bor_next;
  logic [WIDTH-1:0] res_next;

  // Full subtractor on the current LSBs and the running borrow.
  assign d_bit    = a_sr[0] ^ b_sr[0] ^ bor;
  assign bor_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
  assign res_next = {d_bit, res_sr[WIDTH-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      bor        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          bor    <= bor_next;
          cnt    <= cnt + CW'(1);
          // The final bit is folded in directly so diff is complete on entry to DONE.
          if (cnt == LAST_IDX) begin
            diff       <= res_next;
            borrow_out <= bor_next;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
